// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: address/instruction widths,
// fetch FSM encodings, the default reset PC and the sequential-PC helper.
package fetch_unit_pkg;

   localparam int unsigned MEM_ADDR_BUS_W = 32;
   localparam int unsigned INST_W         = 32;

   localparam logic [MEM_ADDR_BUS_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_ST = 2'd0,
      HOLD_ST  = 2'd1,
      DROP_ST  = 2'd2
   } fetch_state_e;

   // Sequential successor; wraps modulo 2^32.
   function automatic logic [MEM_ADDR_BUS_W-1:0] seq_next_pc(input logic [MEM_ADDR_BUS_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, inst, pred} holding register with load/unload/clear
// controls; clear and unload take priority over load.
module if_skid_buffer
   import fetch_unit_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic                      unload,
   input  logic                      clear,
   input  logic [MEM_ADDR_BUS_W-1:0] in_pc,
   input  logic [INST_W-1:0]         in_inst,
   input  logic                      in_pred,
   output logic                      out_valid,
   output logic [MEM_ADDR_BUS_W-1:0] out_pc,
   output logic [INST_W-1:0]         out_inst,
   output logic                      out_pred
);

   logic                      valid_q, valid_d;
   logic [MEM_ADDR_BUS_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0]         inst_q, inst_d;
   logic                      pred_q, pred_d;

   // Next-entry selection.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      pred_d  = pred_q;
      if (clear || unload) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = in_pc;
         inst_d  = in_inst;
         pred_d  = in_pred;
      end else begin
         valid_d = valid_q;
      end
   end

   // Entry register.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0000_0000;
         inst_q  <= 32'h0000_0000;
         pred_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pred_q  <= pred_d;
      end
   end

   assign out_valid = valid_q;
   assign out_pc    = pc_q;
   assign out_inst  = inst_q;
   assign out_pred  = pred_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, single-outstanding memory port,
// one-entry skid and redirect/drop handling. Optional macro: FETCH_PREDICT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [MEM_ADDR_BUS_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic [MEM_ADDR_BUS_W-1:0] bp_pc,
   input  logic [MEM_ADDR_BUS_W-1:0] bp_next_pc,
   input  logic                      bp_prediction,
   output logic                      mem_req,
   output logic [MEM_ADDR_BUS_W-1:0] mem_addr,
   input  logic                      mem_ready,
   input  logic [INST_W-1:0]         mem_data,
   input  logic                      stall,
   input  logic                      redirect,
   input  logic [MEM_ADDR_BUS_W-1:0] redirect_pc,
   output logic                      if_valid,
   output logic [MEM_ADDR_BUS_W-1:0] if_pc,
   output logic [INST_W-1:0]         if_inst,
   output logic                      if_prediction
);

   fetch_state_e              state_q, state_d;
   logic [MEM_ADDR_BUS_W-1:0] pc_q, pc_d;
   logic [MEM_ADDR_BUS_W-1:0] req_addr_q, req_addr_d;
   logic                      if_valid_q, if_valid_d;
   logic [MEM_ADDR_BUS_W-1:0] if_pc_q, if_pc_d;
   logic [INST_W-1:0]         if_inst_q, if_inst_d;
   logic                      if_pred_q, if_pred_d;

   logic [MEM_ADDR_BUS_W-1:0] next_pc_s;
   logic                      pred_s;
   logic                      slot_free_s;
   logic                      mem_req_s;
   logic [MEM_ADDR_BUS_W-1:0] mem_addr_s;
   logic                      skid_load_s, skid_unload_s, skid_clear_s;
   logic                      skid_valid_s;
   logic [MEM_ADDR_BUS_W-1:0] skid_pc_s;
   logic [INST_W-1:0]         skid_inst_s;
   logic                      skid_pred_s;

`ifdef FETCH_PREDICT_EN
   assign next_pc_s = bp_next_pc;
   assign pred_s    = bp_prediction;
`else
   logic unused_bp_s;
   assign next_pc_s   = seq_next_pc(pc_q);
   assign pred_s      = 1'b0;
   assign unused_bp_s = ^{bp_next_pc, bp_prediction};
`endif

   assign slot_free_s = !if_valid_q || !stall;

   if_skid_buffer u_skid (
      .clock     (clock),
      .reset     (reset),
      .load      (skid_load_s),
      .unload    (skid_unload_s),
      .clear     (skid_clear_s),
      .in_pc     (pc_q),
      .in_inst   (mem_data),
      .in_pred   (pred_s),
      .out_valid (skid_valid_s),
      .out_pc    (skid_pc_s),
      .out_inst  (skid_inst_s),
      .out_pred  (skid_pred_s)
   );

   // Next-state, memory port and output-slot control; redirect overrides last.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_addr_d    = req_addr_q;
      if_pc_d       = if_pc_q;
      if_inst_d     = if_inst_q;
      if_pred_d     = if_pred_q;
      skid_load_s   = 1'b0;
      skid_unload_s = 1'b0;
      skid_clear_s  = 1'b0;
      mem_req_s     = 1'b0;
      mem_addr_s    = pc_q;

      if (if_valid_q && !stall) begin
         if_valid_d = 1'b0;
      end else begin
         if_valid_d = if_valid_q;
      end

      case (state_q)
         FETCH_ST: begin
            mem_req_s  = 1'b1;
            mem_addr_s = pc_q;
            req_addr_d = pc_q;
            if (mem_ready) begin
               pc_d = next_pc_s;
               if (slot_free_s) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc_q;
                  if_inst_d  = mem_data;
                  if_pred_d  = pred_s;
               end else begin
                  skid_load_s = 1'b1;
                  state_d     = HOLD_ST;
               end
            end else begin
               state_d = FETCH_ST;
            end
         end
         HOLD_ST: begin
            if (slot_free_s) begin
               if_valid_d    = skid_valid_s;
               if_pc_d       = skid_pc_s;
               if_inst_d     = skid_inst_s;
               if_pred_d     = skid_pred_s;
               skid_unload_s = 1'b1;
               state_d       = FETCH_ST;
            end else begin
               state_d = HOLD_ST;
            end
         end
         DROP_ST: begin
            mem_req_s  = 1'b1;
            mem_addr_s = req_addr_q;
            if (mem_ready) begin
               state_d = FETCH_ST;
            end else begin
               state_d = DROP_ST;
            end
         end
         default: begin
            state_d = FETCH_ST;
         end
      endcase

      // A retiring drop still returns to FETCH so the port cannot deadlock.
      if (redirect) begin
         pc_d          = redirect_pc;
         if_valid_d    = 1'b0;
         skid_load_s   = 1'b0;
         skid_unload_s = 1'b0;
         skid_clear_s  = 1'b1;
         case (state_q)
            FETCH_ST: state_d = mem_ready ? FETCH_ST : DROP_ST;
            HOLD_ST:  state_d = FETCH_ST;
            DROP_ST:  state_d = mem_ready ? FETCH_ST : DROP_ST;
            default:  state_d = FETCH_ST;
         endcase
      end else begin
         skid_clear_s = 1'b0;
      end
   end

   // State and output-slot registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= FETCH_ST;
         pc_q       <= RESET_PC;
         req_addr_q <= 32'h0000_0000;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0000_0000;
         if_inst_q  <= 32'h0000_0000;
         if_pred_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_pred_q  <= if_pred_d;
      end
   end

   assign bp_pc         = pc_q;
   assign mem_req       = mem_req_s;
   assign mem_addr      = mem_addr_s;
   assign if_valid      = if_valid_q;
   assign if_pc         = if_pc_q;
   assign if_inst       = if_inst_q;
   assign if_prediction = if_pred_q;

endmodule
